car_exit_controller: RTL

//  Exit-side counterpart of the car_parking entry gate. Records every car the entry side reports as parked
//  (vehicle number + entry timestamp). At the exit it looks the vehicle up, computes the parking fee and

---
 rtl/car_exit_controller_pkg.sv | 10 +
 rtl/car_exit_controller_slot_table.sv | 66 ++++++
 rtl/car_exit_controller.sv | 99 +++++++++
 3 files changed

// File: rtl/car_exit_controller_pkg.sv
// car_exit_controller_pkg: shared FSM encoding, default sizes and fee arithmetic
package car_exit_controller_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_PAY, OPEN, ERR, CLEAR} state_t;
  localparam int SLOTS_D = 4;
  localparam int VNO_W_D = 32;
  localparam int TS_W_D = 16;
  function automatic logic [31:0] fee_calc(logic [31:0] dur, int unit_shift, int rate);
    return ((dur >> unit_shift) + 32'd1) * 32'(rate);
  endfunction
endpackage

// File: rtl/car_exit_controller_slot_table.sv
// car_exit_controller_slot_table: bay table with registration, lookup match, free-by-index and occupancy
module car_exit_controller_slot_table import car_exit_controller_pkg::*; #(
  parameter int SLOTS = SLOTS_D,
  parameter int VNO_W = VNO_W_D,
  parameter int TS_W = TS_W_D,
  parameter int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  parameter int OCC_W = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_valid,
  input  logic [VNO_W-1:0] entry_vehicle_no,
  input  logic [TS_W-1:0]  ts,
  input  logic             free_en,
  input  logic [IDX_W-1:0] free_idx,
  input  logic [VNO_W-1:0] match_vno,
  output logic             match_hit,
  output logic [IDX_W-1:0] match_idx,
  output logic [TS_W-1:0]  match_ts,
  output logic             entry_drop,
  output logic [OCC_W-1:0] occupancy
);
  logic [SLOTS-1:0] valid;
  logic [VNO_W-1:0] vno [SLOTS];
  logic [TS_W-1:0] ets [SLOTS];
  logic [IDX_W-1:0] free_slot;
  logic free_hit, dup, accept;
  always_comb begin
    free_hit = 1'b0;
    free_slot = '0;
    dup = 1'b0;
    match_hit = 1'b0;
    match_idx = '0;
    occupancy = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_hit = 1'b1;
        free_slot = IDX_W'(i);
      end
      if (valid[i] && vno[i] == entry_vehicle_no) dup = 1'b1;
      if (valid[i] && vno[i] == match_vno) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      occupancy = occupancy + OCC_W'(valid[i]);
    end
  end
  assign accept = entry_valid && free_hit && !dup;
  assign match_ts = ets[match_idx];
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      entry_drop <= 1'b0;
    end else begin
      entry_drop <= entry_valid && !accept;
      if (free_en) valid[free_idx] <= 1'b0;
      if (accept) valid[free_slot] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      vno[free_slot] <= entry_vehicle_no;
      ets[free_slot] <= ts;
    end
  end
endmodule

// File: rtl/car_exit_controller.sv
// car_exit_controller: exit gate that looks up parked cars, bills by duration, takes payment and opens the gate
module car_exit_controller import car_exit_controller_pkg::*; #(
  parameter int SLOTS = SLOTS_D,
  parameter int VNO_W = VNO_W_D,
  parameter int TS_W = TS_W_D,
  parameter int UNIT_SHIFT = 4,
  parameter int RATE = 5,
  parameter int FEE_W = 16,
  parameter int GATE_CYCLES = 4,
  parameter int PAY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         entry_valid,
  input  logic [VNO_W-1:0]             entry_vehicle_no,
  input  logic                         vehicle_present,
  input  logic [VNO_W-1:0]             exit_vehicle_no,
  input  logic                         payment_valid,
  input  logic [FEE_W-1:0]             payment_amount,
  output logic [FEE_W-1:0]             fee_due,
  output logic                         fee_valid,
  output logic                         exit_gate,
  output logic                         car_exited,
  output logic                         exit_error,
  output logic                         entry_drop,
  output logic [$clog2(SLOTS+1)-1:0]   occupancy,
  output logic                         lot_full
);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int OCC_W = $clog2(SLOTS + 1);
  localparam int CNT_W = $clog2((PAY_TIMEOUT > GATE_CYCLES ? PAY_TIMEOUT : GATE_CYCLES) + 1);
  state_t state, state_n;
  logic [TS_W-1:0] ts, match_ts, dur;
  logic [VNO_W-1:0] exit_vno;
  logic [IDX_W-1:0] match_idx, slot;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [FEE_W-1:0] fee;
  logic match_hit, paid, free_en;
  car_exit_controller_slot_table #(
    .SLOTS(SLOTS), .VNO_W(VNO_W), .TS_W(TS_W), .IDX_W(IDX_W), .OCC_W(OCC_W)
  ) u_table (
    .clk(clk),
    .reset(reset),
    .entry_valid(entry_valid),
    .entry_vehicle_no(entry_vehicle_no),
    .ts(ts),
    .free_en(free_en),
    .free_idx(slot),
    .match_vno(exit_vno),
    .match_hit(match_hit),
    .match_idx(match_idx),
    .match_ts(match_ts),
    .entry_drop(entry_drop),
    .occupancy(occupancy)
  );
  assign dur = ts - match_ts;
  assign fee = FEE_W'(fee_calc(32'(dur), UNIT_SHIFT, RATE));
  assign paid = payment_valid && payment_amount >= fee_due;
  assign free_en = state == WAIT_PAY && paid;
  assign fee_valid = state == WAIT_PAY;
  assign exit_gate = state == OPEN;
  assign car_exited = state == OPEN && cnt == CNT_W'(GATE_CYCLES - 1);
  assign exit_error = state == ERR;
  assign lot_full = occupancy == OCC_W'(SLOTS);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = vehicle_present ? LOOKUP : IDLE;
      LOOKUP:   state_n = match_hit ? WAIT_PAY : ERR;
      WAIT_PAY: state_n = payment_valid ? (paid ? OPEN : ERR) : (cnt == CNT_W'(PAY_TIMEOUT - 1) ? ERR : WAIT_PAY);
      OPEN:     state_n = car_exited ? CLEAR : OPEN;
      ERR:      state_n = CLEAR;
      CLEAR:    state_n = vehicle_present ? CLEAR : IDLE;
      default:  state_n = IDLE;
    endcase
    cnt_n = (state_n == state) ? cnt + CNT_W'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ts <= '0;
      cnt <= '0;
      fee_due <= '0;
      exit_vno <= '0;
      slot <= '0;
    end else begin
      state <= state_n;
      ts <= ts + TS_W'(1);
      cnt <= cnt_n;
      if (state == IDLE) exit_vno <= exit_vehicle_no;
      if (state == LOOKUP && match_hit) begin
        fee_due <= fee;
        slot <= match_idx;
      end else if (state == CLEAR && !vehicle_present) begin
        fee_due <= '0;
      end
    end
  end
endmodule
